mmio_uart_tx: RTL and testbench

- Memory-mapped UART transmitter on the core's data-memory bus, in parallel with data_memory.
- Decodes core stores to a small address window and queues bytes in a FIFO.
- Serializes queued bytes 8N1 on a tx pin.
- Exposes a read-only status word, so firmware can poll before writing.

---
 rtl/mmio_uart_tx.sv | 235 +++++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_uart_tx
//  Description : Memory-mapped 8N1 UART transmitter. It sits on the core's
//                data-memory bus next to data_memory. Stores to TXDATA are
//                queued in a small FIFO and shifted out LSB first on tx.
//                Firmware polls a read-only STATUS word before writing.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk      in   1   system clock, rising edge
//    rst      in   1   synchronous active-high reset
//    W_en     in   1   core store strobe
//    R_en     in   1   core load strobe
//    addr     in   32  core data address
//    RW_type  in   3   funct3 access type (accepted, width ignored)
//    WD       in   32  core store data
//    hit      out  1   address falls in this block's 8-byte window
//    RD       out  32  load data (STATUS or zero)
//    tx       out  1   serial line, idle high, registered
//    tx_idle  out  1   FIFO empty and serializer idle
//
//  Register map (addr[2] selects, addr[1:0] ignored)
//    +0 TXDATA  W: push WD[7:0]          R: 0
//    +4 STATUS  W: WD[3]=1 clears ovf    R: {24'b0, count, ovf, busy, empty, full}
// ============================================================================
module mmio_uart_tx #(
   parameter int          CLK_DIV    = 16,
   parameter int          FIFO_DEPTH = 8,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        W_en,
   input  logic        R_en,
   input  logic [31:0] addr,
   input  logic [2:0]  RW_type,
   input  logic [31:0] WD,
   output logic        hit,
   output logic [31:0] RD,
   output logic        tx,
   output logic        tx_idle
);

   localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int c_CNT_W = c_PTR_W + 1;
   localparam int c_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [c_CNT_W-1:0] c_FULL     = c_CNT_W'(FIFO_DEPTH);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
   localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
   localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
   localparam logic [c_DIV_W-1:0] c_DIV_ONE  = c_DIV_W'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   // FIFO state
   logic [7:0]         r_mem [FIFO_DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_CNT_W-1:0] r_count;
   logic               r_overflow;

   // Serializer state
   state_t             r_state;
   logic [c_DIV_W-1:0] r_cnt;
   logic [2:0]         r_bit_idx;
   logic [7:0]         r_shift;
   logic               r_tx;

   logic               w_empty;
   logic               w_full;
   logic               w_busy;
   logic               w_bit_end;
   logic               w_pop;
   logic               w_push_req;
   logic               w_push_ok;
   logic               w_ovf_set;
   logic               w_ovf_clr;
   logic [7:0]         w_head;
   logic [3:0]         w_count_field;
   logic [31:0]        w_status;
   logic               w_unused;

   // ------------------------------------------------------------------------
   // Address decode and bus strobes
   // ------------------------------------------------------------------------
   assign hit        = (addr[31:3] == BASE_ADDR[31:3]);
   assign w_push_req = W_en & hit & ~addr[2];
   assign w_ovf_clr  = W_en & hit &  addr[2] & WD[3];

   // Width hint and upper store-data bits are intentionally ignored.
   assign w_unused   = ^{RW_type, addr[1:0], WD[31:8]};

   // ------------------------------------------------------------------------
   // FIFO control
   // ------------------------------------------------------------------------
   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == c_FULL);
   assign w_head    = r_mem[r_rd_ptr];
   assign w_bit_end = (r_cnt == c_DIV_LAST);
   assign w_busy    = (r_state != S_IDLE);

   // The serializer pulls a byte either from idle or at the last cycle of a
   // stop bit, which is what lets frames run back to back.
   assign w_pop     = ~w_empty & ((r_state == S_IDLE) |
                                  ((r_state == S_STOP) & w_bit_end));

   // A full FIFO still accepts a byte when a pop frees a slot this cycle.
   assign w_push_ok = w_push_req & (~w_full | w_pop);
   assign w_ovf_set = w_push_req & ~w_push_ok;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         end
         case ({w_push_ok, w_pop})
            2'b10:   r_count <= r_count + c_CNT_ONE;
            2'b01:   r_count <= r_count - c_CNT_ONE;
            default: r_count <= r_count;
         endcase
         // Set has priority so a drop is never lost to a concurrent clear.
         if (w_ovf_set) begin
            r_overflow <= 1'b1;
         end else if (w_ovf_clr) begin
            r_overflow <= 1'b0;
         end
      end
   end

   // Storage needs no reset; pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= WD[7:0];
      end
   end

   // ------------------------------------------------------------------------
   // 8N1 serializer
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_tx      <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_tx  <= 1'b1;
               r_cnt <= '0;
               if (w_pop) begin
                  r_shift <= w_head;
                  r_tx    <= 1'b0;
                  r_state <= S_START;
               end
            end

            S_START: begin
               if (w_bit_end) begin
                  r_cnt     <= '0;
                  r_bit_idx <= '0;
                  r_tx      <= r_shift[0];
                  r_state   <= S_DATA;
               end else begin
                  r_cnt <= r_cnt + c_DIV_ONE;
               end
            end

            S_DATA: begin
               if (w_bit_end) begin
                  r_cnt   <= '0;
                  r_shift <= {1'b0, r_shift[7:1]};
                  if (r_bit_idx == 3'd7) begin
                     r_tx    <= 1'b1;
                     r_state <= S_STOP;
                  end else begin
                     r_bit_idx <= r_bit_idx + 3'd1;
                     // Next bit is what lands in shift[0] after this shift.
                     r_tx      <= r_shift[1];
                  end
               end else begin
                  r_cnt <= r_cnt + c_DIV_ONE;
               end
            end

            S_STOP: begin
               if (w_bit_end) begin
                  r_cnt <= '0;
                  if (w_pop) begin
                     r_shift <= w_head;
                     r_tx    <= 1'b0;
                     r_state <= S_START;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_cnt <= r_cnt + c_DIV_ONE;
               end
            end

            default: begin
               r_state <= S_IDLE;
               r_tx    <= 1'b1;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign w_count_field = 4'(r_count);
   assign w_status      = {24'b0, w_count_field, r_overflow, w_busy, w_empty, w_full};
   assign RD            = (R_en & hit & addr[2]) ? w_status : 32'b0;
   assign tx            = r_tx;
   assign tx_idle       = w_empty & ~w_busy;

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mmio_uart_tx
//  Description : Self-checking bench for mmio_uart_tx (CLK_DIV=4, depth 8).
//                Bytes accepted by the bus are queued as expected frames; a
//                line monitor decodes tx and compares each frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_uart_tx;

   localparam int          CLK_DIV    = 4;
   localparam int          FIFO_DEPTH = 8;
   localparam logic [31:0] BASE       = 32'h0000_1000;
   localparam int          FRAME      = 10 * CLK_DIV;

   logic        clk;
   logic        rst;
   logic        W_en;
   logic        R_en;
   logic [31:0] addr;
   logic [2:0]  RW_type;
   logic [31:0] WD;
   logic        hit;
   logic [31:0] RD;
   logic        tx;
   logic        tx_idle;

   mmio_uart_tx #(
      .CLK_DIV    (CLK_DIV),
      .FIFO_DEPTH (FIFO_DEPTH),
      .BASE_ADDR  (BASE)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .W_en    (W_en),
      .R_en    (R_en),
      .addr    (addr),
      .RW_type (RW_type),
      .WD      (WD),
      .hit     (hit),
      .RD      (RD),
      .tx      (tx),
      .tx_idle (tx_idle)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int pcyc = 0;
   always @(posedge clk) pcyc <= pcyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   // ------------------------------------------------------------------------
   // Scoreboard and line monitor
   // ------------------------------------------------------------------------
   logic [7:0] exp_q[$];
   int         starts[$];
   bit         mon_active = 1'b0;
   int         mon_pos;
   logic       mon_s [FRAME];

   task automatic check_frame();
      bit         stable;
      logic [7:0] got;
      stable = 1'b1;
      for (int k = 0; k < 10; k++) begin
         for (int j = 1; j < CLK_DIV; j++) begin
            if (mon_s[k*CLK_DIV+j] !== mon_s[k*CLK_DIV]) stable = 1'b0;
         end
      end
      for (int k = 0; k < 8; k++) got[k] = mon_s[(k+1)*CLK_DIV];
      chk1("frame_bits_stable", stable, 1'b1);
      chk1("frame_stop_bit", mon_s[9*CLK_DIV], 1'b1);
      chk1("frame_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
         chk32("frame_data", {24'b0, got}, {24'b0, exp_q.pop_front()});
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (rst === 1'b1) begin
            mon_active = 1'b0;
         end else if (!mon_active) begin
            if (tx === 1'b0) begin
               mon_active = 1'b1;
               mon_s[0]   = 1'b0;
               mon_pos    = 1;
               starts.push_back(pcyc);
            end
         end else begin
            mon_s[mon_pos] = tx;
            mon_pos++;
            if (mon_pos == FRAME) begin
               mon_active = 1'b0;
               check_frame();
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Helpers
   // ------------------------------------------------------------------------
   task automatic bus(input logic w, input logic r, input logic [31:0] a,
                      input logic [31:0] d, input logic [2:0] t);
      W_en    = w;
      R_en    = r;
      addr    = a;
      WD      = d;
      RW_type = t;
   endtask

   task automatic bus_idle();
      bus(1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
   endtask

   task automatic wait_drain(input string name, input int max_cyc);
      int k;
      k = 0;
      while (k < max_cyc && !(exp_q.size() == 0 && tx_idle === 1'b1 && !mon_active)) begin
         @(negedge clk);
         k++;
      end
      chk1(name, k < max_cyc, 1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // ------------------------------------------------------------------------
   // Decode vectors
   // ------------------------------------------------------------------------
   typedef struct {
      logic        w_en;
      logic        r_en;
      logic [31:0] a;
      logic [31:0] d;
      logic        exp_hit;
      logic [31:0] exp_rd;
   } vec_t;

   localparam int NVEC = 12;
   vec_t vecs [NVEC];

   int e0;

   initial begin
      vecs[0]  = '{1'b0, 1'b1, BASE + 32'd4,  32'h0,  1'b1, 32'h2};
      vecs[1]  = '{1'b0, 1'b1, BASE,          32'h0,  1'b1, 32'h0};
      vecs[2]  = '{1'b0, 1'b1, BASE + 32'd7,  32'h0,  1'b1, 32'h2};
      vecs[3]  = '{1'b0, 1'b1, BASE + 32'd8,  32'h0,  1'b0, 32'h0};
      vecs[4]  = '{1'b0, 1'b1, BASE - 32'd4,  32'h0,  1'b0, 32'h0};
      vecs[5]  = '{1'b1, 1'b0, BASE + 32'd8,  32'hA5, 1'b0, 32'h0};
      vecs[6]  = '{1'b1, 1'b0, BASE - 32'd4,  32'h5A, 1'b0, 32'h0};
      vecs[7]  = '{1'b0, 1'b0, BASE + 32'd4,  32'h0,  1'b1, 32'h0};
      vecs[8]  = '{1'b0, 1'b1, BASE + 32'd4,  32'h0,  1'b1, 32'h2};
      vecs[9]  = '{1'b0, 1'b1, 32'h8000_1004, 32'h0,  1'b0, 32'h0};
      vecs[10] = '{1'b1, 1'b0, BASE + 32'd4,  32'h8,  1'b1, 32'h0};
      vecs[11] = '{1'b0, 1'b1, BASE + 32'd4,  32'h0,  1'b1, 32'h2};

      rst = 1'b1;
      bus_idle();

      // ---- Reset state --------------------------------------------------
      repeat (3) @(negedge clk);
      chk1("reset_tx", tx, 1'b1);
      chk1("reset_tx_idle", tx_idle, 1'b1);
      rst = 1'b0;

      // ---- Decode table (outside stores must leave FIFO empty) ---------
      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk);
         bus(vecs[i].w_en, vecs[i].r_en, vecs[i].a, vecs[i].d, 3'b010);
         #1;
         chk1($sformatf("vec%0d_hit", i), hit, vecs[i].exp_hit);
         chk32($sformatf("vec%0d_rd", i), RD, vecs[i].exp_rd);
      end
      @(negedge clk);
      bus_idle();
      @(negedge clk);
      chk1("decode_tx_idle", tx_idle, 1'b1);
      chk1("decode_tx", tx, 1'b1);

      // ---- Single byte, latency and frame length -----------------------
      bus(1'b1, 1'b0, BASE, 32'h0000_00A5, 3'b000);
      exp_q.push_back(8'hA5);
      @(negedge clk);                 // just after store edge E
      bus_idle();
      chk1("single_tx_before_pop", tx, 1'b1);
      chk1("single_tx_idle_queued", tx_idle, 1'b0);
      @(negedge clk);                 // after E+1
      chk1("single_tx_start", tx, 1'b0);
      repeat (FRAME - 1) @(negedge clk);
      chk1("single_busy_last_stop", tx_idle, 1'b0);
      @(negedge clk);
      chk1("single_idle_after", tx_idle, 1'b1);
      chk32("single_sb_empty", 32'(exp_q.size()), 32'd0);

      // ---- Burst of 10 stores, overflow, clear, push-on-pop -------------
      starts.delete();
      e0 = pcyc + 1;
      for (int i = 0; i < 10; i++) begin
         bus(1'b1, 1'b0, BASE + 32'(i % 4), {24'hDEADBE, 8'(8'h30 + i)}, 3'b010);
         if (i <= FIFO_DEPTH) exp_q.push_back(8'(8'h30 + i));
         @(negedge clk);
      end
      bus(1'b0, 1'b1, BASE + 32'd4, 32'h0, 3'b010);
      #1;
      chk32("burst_status_full_ovf", RD, 32'h0000_008D);
      @(negedge clk);
      bus(1'b1, 1'b0, BASE + 32'd4, 32'h0000_0008, 3'b010);
      @(negedge clk);
      bus(1'b0, 1'b1, BASE + 32'd6, 32'h0, 3'b010);
      #1;
      chk32("burst_status_cleared", RD, 32'h0000_0085);
      @(negedge clk);
      bus_idle();

      while (pcyc < e0 + FRAME - 1) @(negedge clk);
      bus(1'b0, 1'b1, BASE + 32'd4, 32'h0, 3'b010);
      #1;
      chk32("pushpop_status_before", RD, 32'h0000_0085);
      @(negedge clk);                 // store lands on the stop-bit pop edge
      bus(1'b1, 1'b0, BASE, 32'h0000_005A, 3'b010);
      exp_q.push_back(8'h5A);
      @(negedge clk);
      bus(1'b0, 1'b1, BASE + 32'd4, 32'h0, 3'b010);
      #1;
      chk32("pushpop_status_after", RD, 32'h0000_0085);
      @(negedge clk);
      bus_idle();

      wait_drain("burst_drain", 12 * FRAME);
      chk32("burst_frame_count", 32'(starts.size()), 32'd10);
      for (int k = 1; k < starts.size(); k++) begin
         chk32($sformatf("burst_gap%0d", k), 32'(starts[k] - starts[k-1]), 32'(FRAME));
      end

      // ---- Reset in the middle of data bit 3 ----------------------------
      @(negedge clk);
      e0 = pcyc + 1;
      bus(1'b1, 1'b0, BASE, 32'h0000_00C3, 3'b010);
      @(negedge clk);
      bus(1'b1, 1'b0, BASE, 32'h0000_003C, 3'b010);
      @(negedge clk);
      bus(1'b1, 1'b0, BASE, 32'h0000_0081, 3'b010);
      @(negedge clk);
      bus_idle();
      while (pcyc < e0 + 18) @(negedge clk);
      chk1("rstmid_tx_bit3", tx, 1'b0);
      rst = 1'b1;
      exp_q.delete();
      bus(1'b0, 1'b1, BASE + 32'd4, 32'h0, 3'b010);
      @(negedge clk);
      #1;
      chk1("rstmid_tx", tx, 1'b1);
      chk1("rstmid_tx_idle", tx_idle, 1'b1);
      chk32("rstmid_status", RD, 32'h0000_0002);
      rst = 1'b0;
      bus_idle();
      begin
         int lows;
         lows = 0;
         for (int c = 0; c < 3 * FRAME; c++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
         end
         chk32("rstmid_no_frames", 32'(lows), 32'd0);
      end
      bus(1'b0, 1'b1, BASE + 32'd4, 32'h0, 3'b010);
      #1;
      chk32("rstmid_status_after", RD, 32'h0000_0002);
      @(negedge clk);
      bus_idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
